clk_div_sched: RTL and testbench
================================

Name: clk_div_sched

Overview:
- Fully synchronous, programmable divide-by-N clock-enable generator and controller for the team's clock-divider datapath (replaces ripple-DFF dividers).
- Sequences start/stop with no truncated pulses and accepts run-time ratio changes over a req/ack handshake.
- Ratio changes take effect only at period boundaries, so div_out never produces a runt pulse.
- Outputs feed downstream logic as a divided waveform (div_out) and a one-cycle period strobe (tick).

Parameters:
- CNT_W, 8, width of divide ratio and internal counter.
- DEFAULT_DIV, 9, ratio loaded at reset; must satisfy 2 <= DEFAULT_DIV <= 2^CNT_W-1.

Ports:
- clk  in  1  single system clock; all flops on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-low (rst==0 resets on next clk edge).
- en  in  1  run request; level.
- div_val  in  CNT_W  requested divide ratio N; held stable while div_load is high.
- div_load  in  1  ratio-change request; held high until div_ack seen.
- div_ack  out  1  one-cycle pulse: request consumed (applied or rejected).
- div_err  out  1  one-cycle pulse coincident with div_ack when div_val < 2 (rejected).
- div_out  out  1  divided waveform.
- tick  out  1  one-cycle pulse in last cycle of each period.
- busy  out  1  high when state != IDLE.
- cur_div  out  CNT_W  ratio currently in effect.

Behaviour:
- Reset (rst==0 at edge): state=IDLE, cnt=0, cur_div=DEFAULT_DIV, pending=0, div_out=0, tick=0, div_ack=0, div_err=0, busy=0. Reset mid-period truncates immediately; this is the only truncation allowed.
- States:
  - IDLE -> RUN on en==1; cnt=0 in the first RUN cycle, so div_out rises one cycle after en is sampled.
  - RUN -> DRAIN on en==0.
  - DRAIN -> RUN on en==1, with no gap and the count continuing.
  - DRAIN -> IDLE at the period end (cnt==cur_div-1), so the final period is always complete.
- Counter: in RUN and DRAIN, cnt increments each cycle and wraps to 0 after cur_div-1. cnt holds 0 in IDLE.
- div_out is high when state != IDLE and cnt < floor(cur_div/2); otherwise low.
  - N=9: 4 cycles high, 5 low.
  - N=2: 1 high, 1 low.
- tick = (state != IDLE) && cnt == cur_div-1.
- div_out and tick come from flops; their value in a cycle equals the decode of that cycle's state/cnt (computed from next-state). No combinational path from inputs.
- Load handshake:
  - div_load sampled high while pending==0 and div_ack==0: if div_val < 2, pulse div_ack and div_err the next cycle, with no other effect.
  - Otherwise capture div_val into pend_div and set pending=1.
  - While pending==1, further div_load samples are ignored.
  - The requester deasserts div_load the cycle after div_ack. div_load still high in the div_ack cycle is not a new request.
- Apply:
  - In IDLE, pending applies on the next edge: cur_div<=pend_div, div_ack pulses, pending clears.
  - In RUN or DRAIN, pending applies at the period-end edge (the edge leaving cnt==cur_div-1). The new period starts at cnt=0 with the new ratio, and div_ack pulses in that first cycle.
- Simultaneous events:
  - Apply and DRAIN->IDLE on the same edge: both happen; the next start uses the new ratio.
  - en falling on a period-end edge: enter DRAIN for one full extra period. en is evaluated only on the RUN->DRAIN decision, not on the wrap.
- Width: cnt and cur_div are CNT_W bits. N=2^CNT_W-1 is legal. No overflow is possible since cnt <= cur_div-1.

Test Plan:
- Reset then en=1 with default N=9 -> busy=1 one cycle after en sampled; div_out repeats pattern 1111 00000; tick high every 9th cycle (cnt=8); cur_div=9.
- In RUN with N=9, div_val=4, div_load=1 issued at cnt=2 -> no change until the wrap; then div_ack pulses in the cnt=0 cycle, cur_div=4, div_out pattern 1100; no runt pulse.
- div_val=1 load -> div_ack and div_err pulse together one cycle after sampling; cur_div stays 9; waveform undisturbed. Repeat with div_val=0 for the same result.
- en dropped at cnt=3 -> period completes through cnt=8, tick pulses, then IDLE, div_out=0, busy=0. Second run: en re-raised at cnt=6 in DRAIN -> continues into the next period with no gap, busy stays 1.
- rst=0 asserted at cnt=2 with a load pending -> next cycle: div_out=0, busy=0, cur_div=9, pending cleared, no div_ack.
- N=2 and N=255 (CNT_W=8) -> div_out 10 repeating; and 127 high/128 low with tick once per 255 cycles.

Source files
------------

// File: rtl/clk_div_sched_if.sv
// Bundles the run request, ratio-change handshake and divider outputs of
// clk_div_sched. The requester side drives en/div_val/div_load, the divider
// side answers with div_ack/div_err and produces the divided waveform.
interface clk_div_sched_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             div_ack;
  logic             div_err;
  logic             div_out;
  logic             tick;
  logic             busy;
  logic [CNT_W-1:0] cur_div;

  modport master (
    output en, div_val, div_load,
    input  div_ack, div_err, div_out, tick, busy, cur_div
  );

  modport slave (
    input  en, div_val, div_load,
    output div_ack, div_err, div_out, tick, busy, cur_div
  );
endinterface

// File: rtl/clk_div_sched.sv
// Programmable divide-by-N clock-enable generator. A single counter walks
// 0..cur_div-1 while the divider is busy; div_out is high for the first
// floor(cur_div/2) counts and tick marks the last count of each period.
// Stopping drains to the end of the current period and ratio changes wait
// for a period boundary, so the only way to cut a period short is reset.
module clk_div_sched #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 9
) (
  input  logic            clk,
  input  logic            rst,
  clk_div_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] cur_div;
  logic [CNT_W-1:0] cur_div_n;
  logic [CNT_W-1:0] pend_div;
  logic             pending;
  logic             period_end;
  logic             apply;
  logic             div_out_q;
  logic             tick_q;
  logic             ack_q;
  logic             err_q;

  // Next-state decode: sequencing, counter advance and the point at which a
  // pending ratio may be swapped in (immediately when idle, else at the wrap).
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    period_end = (cnt == (cur_div - ONE));
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.en) begin
          state_n = RUN;
        end
      end
      RUN: begin
        cnt_n = period_end ? '0 : (cnt + ONE);
        if (!bus.en) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        cnt_n = period_end ? '0 : (cnt + ONE);
        if (bus.en) begin
          state_n = RUN;
        end else if (period_end) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    apply     = pending && ((state == IDLE) || period_end);
    cur_div_n = apply ? pend_div : cur_div;
  end

  // State, counter, ratio handshake and registered outputs; the outputs are
  // decoded from the next-state values so they line up with the new cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_div   <= DEF_DIV;
      pend_div  <= DEF_DIV;
      pending   <= 1'b0;
      div_out_q <= 1'b0;
      tick_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cur_div   <= cur_div_n;
      div_out_q <= (state_n != IDLE) && (cnt_n < (cur_div_n >> 1));
      tick_q    <= (state_n != IDLE) && (cnt_n == (cur_div_n - ONE));
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      if (apply) begin
        pending <= 1'b0;
        ack_q   <= 1'b1;
      end else if (bus.div_load && !pending && !ack_q) begin
        if (bus.div_val < TWO) begin
          ack_q <= 1'b1;
          err_q <= 1'b1;
        end else begin
          pend_div <= bus.div_val;
          pending  <= 1'b1;
        end
      end
    end
  end

  assign bus.div_out = div_out_q;
  assign bus.tick    = tick_q;
  assign bus.div_ack = ack_q;
  assign bus.div_err = err_q;
  assign bus.busy    = (state != IDLE);
  assign bus.cur_div = cur_div;

endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched: a fixed vector table, directed
// corner-case sequences and a randomized run, all compared every cycle
// against a period-position model of the divider.
module tb_clk_div_sched;

  localparam int CNT_W = 8;
  localparam int DEF   = 9;

  logic clk;
  logic rst;

  clk_div_sched_if #(.CNT_W(CNT_W)) bus ();

  clk_div_sched #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: position within the current period plus run/stop flags.
  int m_active;
  int m_drain;
  int m_pos;
  int m_ratio;
  int m_pend;
  bit m_ack;
  bit m_err;

  typedef struct {
    bit rstn;
    bit en;
    bit load;
    int val;
    bit dout;
    bit tick;
    bit busy;
    bit ack;
    bit err;
    int cur;
  } vec_t;

  vec_t vecs[21];

  // Free-running system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so a stuck design cannot hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void model_step(input bit rstn, input bit en, input bit load, input int val);
    bit endp;
    int nratio;
    if (!rstn) begin
      m_active = 0;
      m_drain  = 0;
      m_pos    = 0;
      m_ratio  = DEF;
      m_pend   = -1;
      m_ack    = 1'b0;
      m_err    = 1'b0;
      return;
    end
    endp   = (m_active != 0) && (m_pos == m_ratio - 1);
    nratio = m_ratio;
    if (m_pend >= 0 && (m_active == 0 || endp)) begin
      nratio = m_pend;
      m_pend = -1;
      m_ack  = 1'b1;
      m_err  = 1'b0;
    end else if (load && m_pend < 0 && !m_ack) begin
      m_ack = (val < 2);
      m_err = (val < 2);
      if (val >= 2) m_pend = val;
    end else begin
      m_ack = 1'b0;
      m_err = 1'b0;
    end
    if (m_active == 0) begin
      m_pos = 0;
      if (en) begin
        m_active = 1;
        m_drain  = 0;
      end
    end else begin
      m_pos = endp ? 0 : m_pos + 1;
      if (m_drain == 0) begin
        m_drain = en ? 0 : 1;
      end else if (en) begin
        m_drain = 0;
      end else if (endp) begin
        m_active = 0;
        m_drain  = 0;
        m_pos    = 0;
      end
    end
    m_ratio = nratio;
  endfunction

  function automatic void checkOutput();
    bit exp_out;
    bit exp_tick;
    exp_out  = (m_active != 0) && (m_pos < m_ratio / 2);
    exp_tick = (m_active != 0) && (m_pos == m_ratio - 1);
    check("model div_out", int'(bus.div_out), int'(exp_out));
    check("model tick",    int'(bus.tick),    int'(exp_tick));
    check("model busy",    int'(bus.busy),    m_active);
    check("model div_ack", int'(bus.div_ack), int'(m_ack));
    check("model div_err", int'(bus.div_err), int'(m_err));
    check("model cur_div", int'(bus.cur_div), m_ratio);
  endfunction

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic applyStimulus(input bit rstn, input bit en, input bit load, input int val);
    rst          = rstn;
    bus.en       = en;
    bus.div_load = load;
    bus.div_val  = CNT_W'(val);
    @(posedge clk);
    model_step(rstn, en, load, val & 255);
    @(negedge clk);
    checkOutput();
  endtask

  // Hold a load request until it is acknowledged, then drop it.
  task automatic doLoad(input int val, input bit en, input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      applyStimulus(1'b1, en, 1'b1, val);
      if (bus.div_ack) begin
        cycles = i;
        break;
      end
    end
    applyStimulus(1'b1, en, 1'b0, 0);
  endtask

  // Run with en low until the divider goes idle, bounded.
  task automatic waitIdle(input int limit, output int cycles, output int ticks);
    cycles = -1;
    ticks  = 0;
    for (int i = 1; i <= limit; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 0);
      if (bus.tick) ticks++;
      if (!bus.busy) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    int tks;
    int highs;
    int lows;
    int acks;
    int lstate;
    int lval;
    int r;
    bit ren;
    bit rr;
    bit ld;

    rst          = 1'b0;
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_val  = '0;
    model_step(1'b0, 1'b0, 1'b0, 0);

    // rstn en ld val | dout tick busy ack err cur
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 9};
    vecs[1]  = '{1, 1, 0, 0, 1, 0, 1, 0, 0, 9};
    vecs[2]  = '{1, 1, 0, 0, 1, 0, 1, 0, 0, 9};
    vecs[3]  = '{1, 1, 0, 0, 1, 0, 1, 0, 0, 9};
    vecs[4]  = '{1, 1, 0, 0, 1, 0, 1, 0, 0, 9};
    vecs[5]  = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 9};
    vecs[6]  = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 9};
    vecs[7]  = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 9};
    vecs[8]  = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 9};
    vecs[9]  = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 9};
    vecs[10] = '{1, 1, 0, 0, 1, 0, 1, 0, 0, 9};
    vecs[11] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 9};
    vecs[12] = '{1, 1, 1, 1, 1, 0, 1, 0, 0, 9};
    vecs[13] = '{1, 1, 0, 0, 1, 0, 1, 0, 0, 9};
    vecs[14] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 9};
    vecs[15] = '{1, 1, 1, 0, 0, 0, 1, 0, 0, 9};
    vecs[16] = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 9};
    vecs[17] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 9};
    vecs[18] = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 9};
    vecs[19] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 9};
    vecs[20] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 9};

    @(negedge clk);
    $display("[TB] vector table");
    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].rstn, vecs[i].en, vecs[i].load, vecs[i].val);
      check("vec div_out", int'(bus.div_out), int'(vecs[i].dout));
      check("vec tick",    int'(bus.tick),    int'(vecs[i].tick));
      check("vec busy",    int'(bus.busy),    int'(vecs[i].busy));
      check("vec div_ack", int'(bus.div_ack), int'(vecs[i].ack));
      check("vec div_err", int'(bus.div_err), int'(vecs[i].err));
      check("vec cur_div", int'(bus.cur_div), vecs[i].cur);
    end

    $display("[TB] ratio change 9 -> 4 mid-period");
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 0);
    doLoad(4, 1'b1, 20, cyc);
    check("load at cnt2 ack latency", cyc, 7);
    check("cur_div after apply", int'(bus.cur_div), 4);
    highs = 0;
    tks   = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 0);
      if (bus.div_out) highs++;
      if (bus.tick) tks++;
    end
    check("N=4 high cycles in 8", highs, 4);
    check("N=4 ticks in 8", tks, 2);

    $display("[TB] stop drains the period, restart in drain");
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 0);
    waitIdle(20, cyc, tks);
    check("drain cycles from cnt3", cyc, 6);
    check("drain final tick", tks, 1);
    check("div_out idle after drain", int'(bus.div_out), 0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 0);
    lows = 0;
    tks  = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 0);
      if (!bus.busy) lows++;
      if (bus.tick) tks++;
    end
    check("busy gaps after re-enable", lows, 0);
    check("ticks after re-enable", tks, 2);

    $display("[TB] reset with a load pending");
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 5);
    applyStimulus(1'b1, 1'b1, 1'b1, 5);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    check("reset div_out", int'(bus.div_out), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset cur_div", int'(bus.cur_div), 9);
    check("reset div_ack", int'(bus.div_ack), 0);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 0);
      if (bus.div_ack) acks++;
    end
    check("acks after reset", acks, 0);
    check("cur_div after reset", int'(bus.cur_div), 9);

    $display("[TB] extreme ratios N=2 and N=255");
    doLoad(2, 1'b0, 10, cyc);
    check("idle load latency N=2", cyc, 2);
    highs = 0;
    tks   = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 0);
      if (bus.div_out) highs++;
      if (bus.tick) tks++;
    end
    check("N=2 high cycles in 10", highs, 5);
    check("N=2 ticks in 10", tks, 5);
    waitIdle(20, cyc, tks);
    check("N=2 drain cycles", cyc, 3);
    doLoad(255, 1'b0, 10, cyc);
    check("idle load latency N=255", cyc, 2);
    check("cur_div N=255", int'(bus.cur_div), 255);
    highs = 0;
    tks   = 0;
    for (int i = 0; i < 510; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 0);
      if (bus.div_out) highs++;
      if (bus.tick) tks++;
    end
    check("N=255 high cycles in 510", highs, 254);
    check("N=255 ticks in 510", tks, 2);
    waitIdle(300, cyc, tks);
    check("N=255 drain cycles", cyc, 256);

    $display("[TB] randomized run");
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    lstate = 0;
    lval   = 0;
    ren    = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      rr = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 19) == 0) ren = ~ren;
      ld = 1'b0;
      case (lstate)
        0: begin
          if ($urandom_range(0, 9) == 0) begin
            r = $urandom_range(0, 15);
            if (r < 2) lval = r;
            else if (r == 15) lval = 255;
            else lval = $urandom_range(2, 12);
            lstate = 1;
            ld     = 1'b1;
          end
        end
        1: begin
          ld = 1'b1;
          if (m_ack) lstate = 2;
        end
        default: begin
          ld     = 1'b0;
          lstate = 0;
        end
      endcase
      if (!rr) begin
        lstate = 0;
        ld     = 1'b0;
      end
      applyStimulus(rr, ren, ld, lval);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
